button_event_scheduler: RTL and testbench

Shared debounce and event scheduler for all front-panel buttons and switches. It samples N raw inputs on one common 50 ms tick and requires consecutive stable samples before changing a debounced level. Each level change becomes a press or release event, and events are serialized into a small FIFO with a valid/ready handshake to the game/control logic. It replaces per-input divider+flop debouncers with one time-shared tick, one counter bank and one event port.

---
 rtl/button_pkg.sv | 13 +
 rtl/event_fifo.sv | 44 ++++
 rtl/button_event_scheduler.sv | 118 +++++++++++
 tb/tb_button_event_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants for the front-panel button debounce/event path.
// Event entries are packed as {id, press}: id in the upper ID_W bits,
// press (1 = rising, 0 = falling) in bit 0.
package button_pkg;
  localparam int TICK_DIV_50MS = 5_000_000;
  localparam int N_BTN_DEF     = 5;
  localparam int ID_W_DEF      = $clog2(N_BTN_DEF);

  // Width of one event entry for a given id width.
  function automatic int evt_width(input int id_w);
    return id_w + 1;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO for button events.
// Ports: clock/reset (sync, active high), push/din write side,
// pop/dout read side (dout shows head, 0 when empty), full/empty status.
// Push while full is accepted only together with a pop.
module event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/button_event_scheduler.sv
// Shared debounce + press/release event scheduler for front-panel inputs.
// Ports: clock, reset (sync, active high), btn_in raw inputs,
// level debounced levels, evt_valid/evt_ready/evt_id/evt_press event port
// (head of FIFO), overflow one-cycle pulse when a pending event is cancelled.
module button_event_scheduler
  import button_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int TICK_DIV   = TICK_DIV_50MS,
  parameter int STABLE_CNT = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(N_BTN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_press,
  output logic             overflow
);
  localparam int TW    = $clog2(TICK_DIV);
  localparam int EVT_W = evt_width(ID_W);

  logic [N_BTN-1:0]      sync1, s;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [N_BTN-1:0][3:0] cnt;
  logic [N_BTN-1:0]      pending, dir, flip;
  logic [N_BTN-1:0]      clr, pend_base, pending_n;
  logic                  ovf_n;
  logic [ID_W-1:0]       sel;
  logic                  push, pop, full, empty;
  logic [EVT_W-1:0]      din, dout;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // An input flips when the tick sees it differ for the STABLE_CNT-th time.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_BTN; i++)
      flip[i] = tick && (s[i] != level[i]) && (cnt[i] == 4'(STABLE_CNT - 1));
  end

  // Priority pick: iterate downward so the lowest set index wins.
  always_comb begin
    sel = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pending[i]) sel = ID_W'(i);
  end

  assign pop  = evt_valid && evt_ready;
  assign push = (|pending) && (!full || pop);
  assign din  = {sel, dir[sel]};

  // The scheduler's clear is applied first and the tick toggle on top, so a
  // bit drained and re-flipped in the same cycle ends up set (new event),
  // while a bit still waiting when its input flips back is cancelled.
  always_comb begin
    clr = '0;
    if (push) clr[sel] = 1'b1;
    pend_base = pending & ~clr;
    pending_n = pend_base ^ flip;
    ovf_n     = |(pend_base & flip);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= '0;
      s        <= '0;
      tick_cnt <= '0;
      cnt      <= '0;
      level    <= '0;
      pending  <= '0;
      dir      <= '0;
      overflow <= 1'b0;
    end else begin
      sync1    <= btn_in;
      s        <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      for (int i = 0; i < N_BTN; i++) begin
        if (tick) begin
          if (s[i] == level[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == 4'(STABLE_CNT - 1)) begin
            level[i] <= s[i];
            dir[i]   <= s[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
      end
      pending  <= pending_n;
      overflow <= ovf_n;
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid = !empty;
  assign evt_id    = dout[EVT_W-1:1];
  assign evt_press = dout[0];
endmodule

// File: tb/tb_button_event_scheduler.sv
// Self-checking bench for button_event_scheduler (TICK_DIV=8, STABLE_CNT=2,
// N_BTN=5, FIFO_DEPTH=4). Expected events go into a queue as stimulus is
// applied; a monitor pops and compares on every accepted handshake.
module tb_button_event_scheduler;
  localparam int N_BTN = 5;
  localparam int ID_W  = 3;
  localparam int TDIV  = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn_in = '0;
  logic [N_BTN-1:0] level;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [ID_W-1:0]  evt_id;
  logic             evt_press;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  int tb_tc = 0;
  logic [ID_W:0] exp_q[$];

  button_event_scheduler #(
    .N_BTN(N_BTN), .TICK_DIV(TDIV), .STABLE_CNT(2), .FIFO_DEPTH(4), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset(reset), .btn_in(btn_in), .level(level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_press(evt_press), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Bench's own view of the tick phase: tick cycle is when tb_tc == TDIV-1.
  always @(posedge clock) begin
    if (reset) tb_tc <= 0;
    else       tb_tc <= (tb_tc == TDIV - 1) ? 0 : tb_tc + 1;
  end

  // Scoreboard monitor: sampled at the edge that performs the handshake.
  always @(posedge clock) begin
    if (!reset && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got id=%0d press=%0d required none", evt_id, evt_press);
      end else begin
        logic [ID_W:0] e;
        e = exp_q.pop_front();
        if ({evt_id, evt_press} !== e) begin
          errors++;
          $display("FAIL event_order got id=%0d press=%0d required id=%0d press=%0d",
                   evt_id, evt_press, e[ID_W:1], e[0]);
        end
      end
    end
    if (!reset && overflow) ovf_cnt++;
  end

  task automatic expect_evt(input int id, input bit press);
    exp_q.push_back({ID_W'(id), press});
  endtask

  // Advance to the negedge of the cycle right after the next tick cycle.
  task automatic tick_end();
    int n = 0;
    while (tb_tc != TDIV - 1 && n < 3 * TDIV) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3 * TDIV) begin
      checks++; errors++;
      $display("FAIL tick_timeout got no tick required tick within %0d cycles", 3 * TDIV);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({level, evt_valid, evt_id, evt_press, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state got level=%b valid=%b id=%0d press=%b ovf=%b required all 0",
               level, evt_valid, evt_id, evt_press, overflow);
    end
  endtask

  task automatic test_press_release();
    tick_end();
    btn_in[2] = 1'b1;
    expect_evt(2, 1'b1);
    tick_end();
    checks++;
    if (level !== 5'b00000) begin
      errors++; $display("FAIL t1_level_first_tick got %b required 00000", level);
    end
    tick_end();
    checks++;
    if (level !== 5'b00100) begin
      errors++; $display("FAIL t1_level_second_tick got %b required 00100", level);
    end
    tick_end(); tick_end();
    btn_in[2] = 1'b0;
    expect_evt(2, 1'b0);
    tick_end(); tick_end();
    checks++;
    if (level !== 5'b00000) begin
      errors++; $display("FAIL t1_level_release got %b required 00000", level);
    end
    tick_end(); tick_end();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL t1_drain got %0d pending expected required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch();
    // Two separated one-tick pulses: if the counter did not return to 0
    // after the first, the second would complete a flip.
    for (int k = 0; k < 2; k++) begin
      tick_end();
      btn_in[1] = 1'b1;
      repeat (TDIV) @(negedge clock);
      btn_in[1] = 1'b0;
      tick_end(); tick_end();
    end
    tick_end();
    checks++;
    if (level !== 5'b00000) begin
      errors++; $display("FAIL t2_glitch_level got %b required 00000", level);
    end
  endtask

  task automatic test_simultaneous();
    tick_end();
    btn_in = 5'b10001;
    tick_end(); tick_end();
    expect_evt(0, 1'b1);
    expect_evt(4, 1'b1);
    checks++;
    if (level !== 5'b10001 || evt_valid !== 1'b0) begin
      errors++; $display("FAIL t3_flip_cycle got level=%b valid=%b required 10001 0", level, evt_valid);
    end
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0 || evt_press !== 1'b1) begin
      errors++; $display("FAIL t3_first_evt got v=%b id=%0d p=%b required 1 0 1", evt_valid, evt_id, evt_press);
    end
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd4 || evt_press !== 1'b1) begin
      errors++; $display("FAIL t3_second_evt got v=%b id=%0d p=%b required 1 4 1", evt_valid, evt_id, evt_press);
    end
    btn_in = '0;
    expect_evt(0, 1'b0);
    expect_evt(4, 1'b0);
    tick_end(); tick_end(); tick_end();
    checks++;
    if (level !== 5'b00000 || exp_q.size() != 0) begin
      errors++; $display("FAIL t3_release got level=%b left=%0d required 00000 0", level, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    tick_end();
    btn_in = 5'b11111;
    for (int i = 0; i < N_BTN; i++) expect_evt(i, 1'b1);
    tick_end(); tick_end();
    repeat (6) @(negedge clock);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0 || dut.pending !== 5'b10000) begin
      errors++; $display("FAIL t4_full got v=%b id=%0d pend=%b required 1 0 10000", evt_valid, evt_id, dut.pending);
    end
    evt_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd1 || dut.pending !== 5'b00000) begin
      errors++; $display("FAIL t4_push_pop_full got v=%b id=%0d pend=%b required 1 1 00000", evt_valid, evt_id, dut.pending);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL t4_drain got v=%b left=%0d required 0 0", evt_valid, exp_q.size());
    end
    btn_in = '0;
    for (int i = 0; i < N_BTN; i++) expect_evt(i, 1'b0);
    tick_end(); tick_end(); tick_end();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL t4_release_drain got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_cancel();
    int ovf_base;
    evt_ready = 1'b0;
    tick_end();
    btn_in = 5'b10111;
    expect_evt(0, 1'b1); expect_evt(1, 1'b1); expect_evt(2, 1'b1); expect_evt(4, 1'b1);
    tick_end(); tick_end();
    ovf_base = ovf_cnt;
    btn_in[3] = 1'b1;
    tick_end(); tick_end();
    checks++;
    if (dut.pending !== 5'b01000 || level[3] !== 1'b1) begin
      errors++; $display("FAIL t5_pending_set got pend=%b lvl3=%b required 01000 1", dut.pending, level[3]);
    end
    btn_in[3] = 1'b0;
    tick_end(); tick_end();
    @(negedge clock);
    checks++;
    if (ovf_cnt - ovf_base != 1 || dut.pending !== 5'b00000 || level[3] !== 1'b0) begin
      errors++; $display("FAIL t5_cancel got ovf=%0d pend=%b lvl3=%b required 1 00000 0",
                         ovf_cnt - ovf_base, dut.pending, level[3]);
    end
    evt_ready = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL t5_drain got v=%b left=%0d required 0 0", evt_valid, exp_q.size());
    end
    btn_in = '0;
    expect_evt(0, 1'b0); expect_evt(1, 1'b0); expect_evt(2, 1'b0); expect_evt(4, 1'b0);
    tick_end(); tick_end(); tick_end();
    checks++;
    if (exp_q.size() != 0 || ovf_cnt - ovf_base != 1) begin
      errors++; $display("FAIL t5_release got left=%0d ovf=%0d required 0 1", exp_q.size(), ovf_cnt - ovf_base);
    end
  endtask

  task automatic test_mid_reset();
    evt_ready = 1'b0;
    tick_end();
    btn_in = 5'b01111;
    tick_end(); tick_end();
    repeat (3) @(negedge clock);
    checks++;
    if (dut.pending !== 5'b01000 || evt_valid !== 1'b1) begin
      errors++; $display("FAIL t6_precond got pend=%b v=%b required 01000 1", dut.pending, evt_valid);
    end
    reset = 1'b1;
    btn_in = '0;
    @(negedge clock);
    checks++;
    if ({level, evt_valid, evt_id, evt_press, overflow} !== '0 || dut.pending !== '0) begin
      errors++; $display("FAIL t6_reset got level=%b v=%b id=%0d p=%b ovf=%b pend=%b required all 0",
                         level, evt_valid, evt_id, evt_press, overflow, dut.pending);
    end
    reset = 1'b0;
    evt_ready = 1'b1;
    tick_end(); tick_end(); tick_end(); tick_end();
    checks++;
    if (evt_valid !== 1'b0 || level !== 5'b00000) begin
      errors++; $display("FAIL t6_no_stale got v=%b level=%b required 0 00000", evt_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_backpressure();
    test_cancel();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_queue got %0d unconsumed required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
